// File: rtl/elev_pkg.sv
// elev_pkg: state and direction codes plus the request-mask helpers shared
// by the N-floor elevator controller.
package elev_pkg;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_IDLE    = 3'd1,
    S_MOVE    = 3'd2,
    S_ARRIVE  = 3'd3,
    S_OPENING = 3'd4,
    S_OPEN    = 3'd5,
    S_CLOSING = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_UP   = 2'd1,
    D_DOWN = 2'd2
  } dir_t;

  // Widest supported building; request vectors are zero-padded to this size
  // so the floors above the top floor never look like pending work.
  localparam int MAX_FLOORS = 16;
  localparam int MAX_FW     = 4;

  // Floors strictly above (up) or strictly below (down) the given floor.
  // An idle direction has nothing ahead of it.
  function automatic logic [MAX_FLOORS-1:0] ahead_mask(input logic [MAX_FW-1:0] fl,
                                                       input dir_t d);
    logic [MAX_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (d == D_UP && i > int'(fl)) m[i] = 1'b1;
      else if (d == D_DOWN && i < int'(fl)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Reverse of a travel direction; idle stays idle.
  function automatic dir_t opposite(input dir_t d);
    case (d)
      D_UP:    return D_DOWN;
      D_DOWN:  return D_UP;
      default: return D_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/elev_tick_timer.sv
// elev_tick_timer: loadable down-counter that decrements on tick strobes and
// parks at zero. One instance times every door and travel phase.
module elev_tick_timer
  import elev_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          tick,
  output logic [CW-1:0] count,
  output logic          done
);

  logic [CW-1:0] count_q;

  // Load has priority so a phase entered on a tick still gets its full time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign done  = (count_q == '0);

endmodule

// File: rtl/elev_ctrl_n.sv
// elev_ctrl_n: N-floor elevator controller with latched hall/car requests,
// SCAN direction policy and tick-timed door phases.
// Optional build macro ELEV_OVERLOAD_EN adds an overload input that holds the
// door open and reopens a closing door.
module elev_ctrl_n
  import elev_pkg::*;
#(
  parameter int N_FLOORS  = 8,
  parameter int FW        = $clog2(N_FLOORS),
  parameter int T_MOVE    = 5,
  parameter int T_OPENING = 2,
  parameter int T_OPEN    = 4,
  parameter int T_CLOSING = 4,
  parameter int CW        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                power,
  input  logic [N_FLOORS-1:0] up_call,
  input  logic [N_FLOORS-1:0] down_call,
  input  logic [N_FLOORS-1:0] car_btn,
  input  logic                door_open_btn,
  input  logic                door_close_btn,
`ifdef ELEV_OVERLOAD_EN
  input  logic                overload,
`endif
  output logic [FW-1:0]       floor,
  output logic [2:0]          state,
  output logic [1:0]          dir,
  output logic                door_open,
  output logic [N_FLOORS-1:0] req_up,
  output logic [N_FLOORS-1:0] req_down,
  output logic [N_FLOORS-1:0] req_car,
  output logic [CW-1:0]       countdown
);

  localparam logic [N_FLOORS-1:0] UP_VALID   = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DOWN_VALID = {{(N_FLOORS-1){1'b1}}, 1'b0};
  localparam logic [FW-1:0]       TOP_FLOOR  = FW'(N_FLOORS - 1);
  localparam logic [CW-1:0]       LD_MOVE    = CW'(T_MOVE);
  localparam logic [CW-1:0]       LD_OPENING = CW'(T_OPENING);
  localparam logic [CW-1:0]       LD_OPEN    = CW'(T_OPEN);
  localparam logic [CW-1:0]       LD_CLOSING = CW'(T_CLOSING);

  state_t                state_q, state_d;
  dir_t                  dir_q, dir_d;
  logic [FW-1:0]         floor_q, floor_d;
  logic [N_FLOORS-1:0]   req_up_q, req_down_q, req_car_q;
  logic                  timer_load, timer_done, reload_open, hold_open;
  logic [CW-1:0]         timer_val, timer_count;
  logic [MAX_FLOORS-1:0] req_any;
  logic [MAX_FW-1:0]     floor_w;
  logic                  ahead_up, ahead_down, ahead_dir, ahead_opp;
  logic                  car_here, up_here, down_here, any_here, match_here, stop_here;
  logic                  serve;
  logic [N_FLOORS-1:0]   floor_bit, clr_up, clr_down, clr_car;

`ifdef ELEV_OVERLOAD_EN
  assign hold_open = overload;
`else
  assign hold_open = 1'b0;
`endif

  assign req_any    = MAX_FLOORS'(req_up_q | req_down_q | req_car_q);
  assign floor_w    = MAX_FW'(floor_q);
  assign ahead_up   = |(req_any & ahead_mask(floor_w, D_UP));
  assign ahead_down = |(req_any & ahead_mask(floor_w, D_DOWN));
  assign ahead_dir  = |(req_any & ahead_mask(floor_w, dir_q));
  assign ahead_opp  = |(req_any & ahead_mask(floor_w, opposite(dir_q)));

  assign car_here   = req_car_q[floor_q];
  assign up_here    = req_up_q[floor_q];
  assign down_here  = req_down_q[floor_q];
  assign any_here   = car_here | up_here | down_here;
  assign match_here = car_here | (dir_q != D_DOWN && up_here) | (dir_q != D_UP && down_here);
  assign stop_here  = car_here
                    | (dir_q == D_UP   && up_here)
                    | (dir_q == D_DOWN && down_here)
                    | (!ahead_dir && (dir_q == D_UP ? down_here : up_here));

  assign serve     = (state_d == S_OPENING) && (state_q != S_OPENING);
  assign floor_bit = N_FLOORS'(1) << floor_q;
  assign clr_car   = serve ? floor_bit : '0;
  assign clr_up    = (serve && dir_q != D_DOWN) ? floor_bit : '0;
  assign clr_down  = (serve && dir_q != D_UP) ? floor_bit : '0;

  elev_tick_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (tick),
    .count    (timer_count),
    .done     (timer_done)
  );

  // Controller state, travel direction and floor position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      dir_q   <= D_IDLE;
      floor_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      floor_q <= floor_d;
    end
  end

  // Request lamps: set by buttons, cleared when served; clear beats set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_up_q   <= '0;
      req_down_q <= '0;
      req_car_q  <= '0;
    end else if (state_q == S_OFF) begin
      req_up_q   <= '0;
      req_down_q <= '0;
      req_car_q  <= '0;
    end else begin
      req_up_q   <= (req_up_q | (up_call & UP_VALID)) & ~clr_up;
      req_down_q <= (req_down_q | (down_call & DOWN_VALID)) & ~clr_down;
      req_car_q  <= (req_car_q | car_btn) & ~clr_car;
    end
  end

  // SCAN next-state decision; power-off is only honoured from IDLE.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    floor_d     = floor_q;
    reload_open = 1'b0;
    case (state_q)
      S_OFF: begin
        if (power) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (any_here || door_open_btn) begin
          state_d = S_OPENING;
        end else if (ahead_up) begin
          dir_d   = D_UP;
          state_d = S_MOVE;
        end else if (ahead_down) begin
          dir_d   = D_DOWN;
          state_d = S_MOVE;
        end else if (!power) begin
          state_d = S_OFF;
        end
      end
      S_MOVE: begin
        if (timer_done) begin
          state_d = S_ARRIVE;
          if (dir_q == D_UP && floor_q != TOP_FLOOR) floor_d = floor_q + FW'(1);
          else if (dir_q == D_DOWN && floor_q != '0) floor_d = floor_q - FW'(1);
        end
      end
      S_ARRIVE: begin
        if (stop_here) begin
          state_d = S_OPENING;
        end else if (ahead_dir) begin
          state_d = S_MOVE;
        end else begin
          dir_d   = D_IDLE;
          state_d = S_IDLE;
        end
      end
      S_OPENING: begin
        if (timer_done) state_d = S_OPEN;
      end
      S_OPEN: begin
        if (hold_open || door_open_btn) reload_open = 1'b1;
        else if (door_close_btn || timer_done) state_d = S_CLOSING;
      end
      S_CLOSING: begin
        if (door_open_btn || match_here || hold_open) begin
          state_d = S_OPENING;
        end else if (timer_done) begin
          if (ahead_dir) begin
            state_d = S_MOVE;
          end else if (ahead_opp) begin
            dir_d   = opposite(dir_q);
            state_d = S_MOVE;
          end else begin
            dir_d   = D_IDLE;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // Reload the shared timer on every state change with the new phase's length.
  always_comb begin
    timer_val  = '0;
    timer_load = reload_open || (state_d != state_q);
    case (state_d)
      S_MOVE:    timer_val = LD_MOVE;
      S_OPENING: timer_val = LD_OPENING;
      S_OPEN:    timer_val = LD_OPEN;
      S_CLOSING: timer_val = LD_CLOSING;
      default:   timer_val = '0;
    endcase
  end

  assign floor     = floor_q;
  assign state     = state_q;
  assign dir       = dir_q;
  assign door_open = (state_q == S_OPEN);
  assign req_up    = req_up_q;
  assign req_down  = req_down_q;
  assign req_car   = req_car_q;
  assign countdown = (state_q inside {S_MOVE, S_OPENING, S_OPEN, S_CLOSING}) ? timer_count : '0;

endmodule
